// File: rtl/gcd_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : gcd_seq_ctrl_pkg
// Brief  : Shared types and defaults for the sequential GCD controller.
// Rev    : 1.0 - initial release
// ============================================================================
package gcd_seq_ctrl_pkg;

  localparam int C_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : gcd_seq_ctrl_pkg
`default_nettype wire

// File: rtl/gcd_step.sv
`default_nettype none
// ============================================================================
// Module : gcd_step
// Brief  : Compare/subtract datapath for one Euclid subtraction step.
// Rev    : 1.0 - initial release
// ============================================================================
module gcd_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] diff
);

  always_comb begin
    a_gt_b = (a > b);
    a_eq_b = (a == b);
    a_zero = (a == '0);
    b_zero = (b == '0);
    // Larger minus smaller only, so the result never borrows.
    diff   = a_gt_b ? (a - b) : (b - a);
  end

endmodule : gcd_step
`default_nettype wire

// File: rtl/gcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gcd_seq_ctrl
// Brief  : Subtraction-based GCD engine with start/busy/done handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module gcd_seq_ctrl
  import gcd_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH:0]   steps
);

  localparam logic [WIDTH:0] C_STEPS_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic [WIDTH:0]   r_steps;

  logic             w_a_gt_b;
  logic             w_a_eq_b;
  logic             w_a_zero;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_diff;
  logic             w_term;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (r_a),
    .b      (r_b),
    .a_gt_b (w_a_gt_b),
    .a_eq_b (w_a_eq_b),
    .a_zero (w_a_zero),
    .b_zero (w_b_zero),
    .diff   (w_diff)
  );

  assign w_term = w_a_zero | w_b_zero | w_a_eq_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_term) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      CALC: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand registers, result and step counter; operands load only from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_gcd   <= '0;
      r_steps <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_steps <= '0;
          end
        end
        CALC: begin
          if (w_a_zero) begin
            r_gcd <= r_b;
          end else if (w_b_zero || w_a_eq_b) begin
            r_gcd <= r_a;
          end else begin
            if (w_a_gt_b) begin
              r_a <= w_diff;
            end else begin
              r_b <= w_diff;
            end
            if (r_steps != C_STEPS_MAX) begin
              r_steps <= r_steps + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gcd_out = r_gcd;
  assign steps   = r_steps;

endmodule : gcd_seq_ctrl
`default_nettype wire
